// File: rtl/rs_encoder_if.sv
// Stream bundle for rs_encoder: message symbols in, codeword symbols plus framing flags out.
// in_last is present only when RS_ENC_SHORTEN_EN is defined. The encoder takes the slave view.
interface rs_encoder_if #(parameter int M = 8);
  logic         in_valid;
  logic         in_ready;
  logic [M-1:0] in_data;
`ifdef RS_ENC_SHORTEN_EN
  logic         in_last;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [M-1:0] out_data;
  logic         out_sop;
  logic         out_eop;
  logic         out_parity;

`ifdef RS_ENC_SHORTEN_EN
  modport slave (input in_valid, in_data, in_last, out_ready,
                 output in_ready, out_valid, out_data, out_sop, out_eop, out_parity);
  modport master (output in_valid, in_data, in_last, out_ready,
                  input in_ready, out_valid, out_data, out_sop, out_eop, out_parity);
`else
  modport slave (input in_valid, in_data, out_ready,
                 output in_ready, out_valid, out_data, out_sop, out_eop, out_parity);
  modport master (output in_valid, in_data, out_ready,
                  input in_ready, out_valid, out_data, out_sop, out_eop, out_parity);
`endif
endinterface

// File: rtl/rs_encoder.sv
// Systematic RS(N,K) encoder over GF(2^8), p(x)=0x11D, generator roots alpha^0..alpha^(2T-1).
// Optional shortened codewords via in_last when RS_ENC_SHORTEN_EN is defined.
package rs_gf_pkg;
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] s;
    p = 8'h00;
    s = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ s;
      s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1D : 8'h00);
    end
    return p;
  endfunction
endpackage

// Multiply by a constant; reduces to a fixed XOR network.
module rs_gf_mul #(parameter logic [7:0] B = 8'h01) (
  input  logic [7:0] a,
  output logic [7:0] p
);
  assign p = rs_gf_pkg::gf_mul(a, B);
endmodule

module rs_encoder #(
  parameter int M = 8,
  parameter int N = 255,
  parameter int K = 239
) (
  input  logic        clk,
  input  logic        rst,
  rs_encoder_if.slave bus
);
  localparam int NPAR = N - K;
  localparam int CW   = $clog2(N + 1);
  localparam logic [CW-1:0] ONE    = CW'(1);
  localparam logic [CW-1:0] K_LAST = CW'(K - 1);
  localparam logic [CW-1:0] P_LAST = CW'(NPAR - 1);

  // Expand prod(x + alpha^i) in place; entry j is the coefficient of x^j.
  function automatic logic [NPAR*8-1:0] gen_poly();
    logic [NPAR:0][7:0] g;
    logic [7:0]         a;
    g    = '0;
    g[0] = 8'h01;
    a    = 8'h01;
    for (int i = 0; i < NPAR; i++) begin
      for (int j = NPAR; j >= 1; j--) g[j] = g[j-1] ^ rs_gf_pkg::gf_mul(g[j], a);
      g[0] = rs_gf_pkg::gf_mul(g[0], a);
      a    = rs_gf_pkg::gf_mul(a, 8'h02);
    end
    return g[NPAR-1:0];
  endfunction

  localparam logic [NPAR*8-1:0] GEN = gen_poly();

  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2} state_t;

  state_t                   state_r;
  logic [CW-1:0]            cnt_r;
  logic [CW-1:0]            pcnt_r;
  logic [NPAR-1:0][M-1:0]   r_r;
  logic                     out_valid_r;
  logic [M-1:0]             out_data_r;
  logic                     out_sop_r;
  logic                     out_eop_r;
  logic                     out_parity_r;

  logic                     out_slot_s;
  logic                     in_fire_s;
  logic                     last_s;
  logic [M-1:0]             fb_s;
  logic [NPAR-1:0][M-1:0]   prod_s;
  logic [NPAR-1:0][M-1:0]   r_next_s;

  assign out_slot_s   = !out_valid_r || bus.out_ready;
  assign bus.in_ready = !rst && (state_r != PARITY) && out_slot_s;
  assign in_fire_s    = bus.in_valid && bus.in_ready;
`ifdef RS_ENC_SHORTEN_EN
  assign last_s       = (cnt_r == K_LAST) || bus.in_last;
`else
  assign last_s       = (cnt_r == K_LAST);
`endif
  assign fb_s         = bus.in_data ^ r_r[NPAR-1];

  assign bus.out_valid  = out_valid_r;
  assign bus.out_data   = out_data_r;
  assign bus.out_sop    = out_sop_r;
  assign bus.out_eop    = out_eop_r;
  assign bus.out_parity = out_parity_r;

  for (genvar gi = 0; gi < NPAR; gi++) begin : g_mul
    rs_gf_mul #(.B(GEN[gi*8 +: 8])) u_mul (.a(fb_s), .p(prod_s[gi]));
  end

  // Next parity register contents for an accepted message symbol.
  always_comb begin
    r_next_s    = '0;
    r_next_s[0] = prod_s[0];
    for (int i = 1; i < NPAR; i++) r_next_s[i] = r_r[i-1] ^ prod_s[i];
  end

  // Control FSM, parity LFSR and the single output register stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      cnt_r        <= '0;
      pcnt_r       <= '0;
      r_r          <= '0;
      out_valid_r  <= 1'b0;
      out_data_r   <= '0;
      out_sop_r    <= 1'b0;
      out_eop_r    <= 1'b0;
      out_parity_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DATA: begin
          if (in_fire_s) begin
            r_r          <= r_next_s;
            out_valid_r  <= 1'b1;
            out_data_r   <= bus.in_data;
            out_sop_r    <= (state_r == IDLE);
            out_eop_r    <= 1'b0;
            out_parity_r <= 1'b0;
            if (last_s) begin
              state_r <= PARITY;
              cnt_r   <= '0;
              pcnt_r  <= '0;
            end else begin
              state_r <= DATA;
              cnt_r   <= cnt_r + ONE;
            end
          end else if (bus.out_ready) begin
            out_valid_r  <= 1'b0;
            out_sop_r    <= 1'b0;
            out_eop_r    <= 1'b0;
            out_parity_r <= 1'b0;
          end
        end
        PARITY: begin
          // Shift only when the output register is free, so a stall freezes r.
          if (out_slot_s) begin
            out_valid_r  <= 1'b1;
            out_data_r   <= r_r[NPAR-1];
            out_sop_r    <= 1'b0;
            out_eop_r    <= (pcnt_r == P_LAST);
            out_parity_r <= 1'b1;
            if (pcnt_r == P_LAST) begin
              state_r <= IDLE;
              pcnt_r  <= '0;
              r_r     <= '0;
            end else begin
              pcnt_r  <= pcnt_r + ONE;
              r_r     <= {r_r[NPAR-2:0], {M{1'b0}}};
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rs_encoder.sv
// Scoreboard bench for rs_encoder: log/antilog GF model, long-division parity, syndrome checks.
module tb_rs_encoder;
  localparam int M  = 8;
  localparam int N  = 255;
  localparam int K  = 239;
  localparam int NP = N - K;

  typedef struct packed {
    logic [7:0] d;
    logic       sop;
    logic       eop;
    logic       par;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rs_encoder_if #(.M(M)) bus();
  rs_encoder #(.M(M), .N(N), .K(K)) dut (.clk(clk), .rst(rst), .bus(bus));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         checks = 0;
  int         errors = 0;
  exp_t       exp_q[$];
  logic [7:0] cw_q[$];
  logic [7:0] ref_cw [0:N-1];
  logic [7:0] msg    [0:K-1];
  logic [7:0] par_m  [0:NP-1];
  logic [7:0] exp_tab [0:254];
  int         log_tab [0:255];
  logic [7:0] g [0:NP];
  int         lat_r;
  int         span_r;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    return exp_tab[(log_tab[a] + log_tab[b]) % 255];
  endfunction

  task automatic init_model();
    logic [7:0] x;
    x = 8'h01;
    for (int i = 0; i < 255; i++) begin
      exp_tab[i] = x;
      log_tab[x] = i;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
    end
    for (int j = 0; j <= NP; j++) g[j] = 8'h00;
    g[0] = 8'h01;
    for (int i = 0; i < NP; i++) begin
      for (int j = i + 1; j >= 1; j--) g[j] = g[j-1] ^ gmul(g[j], exp_tab[i]);
      g[0] = gmul(g[0], exp_tab[i]);
    end
  endtask

  // Long division of zero-prefixed message * x^NP by g(x); remainder highest degree first.
  task automatic model_parity(input int len);
    logic [7:0] u [0:N-1];
    logic [7:0] c;
    for (int i = 0; i < N; i++) u[i] = 8'h00;
    for (int i = 0; i < len; i++) u[K-len+i] = msg[i];
    for (int i = 0; i < K; i++) begin
      c = u[i];
      if (c != 8'h00)
        for (int j = 1; j <= NP; j++) u[i+j] = u[i+j] ^ gmul(c, g[NP-j]);
    end
    for (int k = 0; k < NP; k++) par_m[k] = u[K+k];
  endtask

  // Sends nw words of len symbols (same content); entered and left at posedge+1.
  task automatic drive_words(input int len, input int nw, input bit stall, input bit use_last);
    int   sent, budget, first_in, first_out, last_out;
    bit   hold_v;
    exp_t held, e;
    sent = 0; budget = 0; hold_v = 1'b0;
    first_in = -1; first_out = -1; last_out = -1;
    held = '0;
    cw_q.delete();
    while ((sent < len*nw || exp_q.size() != 0) && budget < 20000) begin
      bus.in_valid  = (sent < len*nw) && (!stall || ($urandom_range(0, 1) == 1));
      bus.in_data   = bus.in_valid ? msg[sent % len] : 8'($urandom);
`ifdef RS_ENC_SHORTEN_EN
      bus.in_last   = bus.in_valid ? (use_last && (sent % len == len - 1)) : 1'($urandom);
`endif
      bus.out_ready = !stall || ($urandom_range(0, 1) == 1);
      @(negedge clk);
      if (hold_v) begin
        chk("stall_valid", 32'(bus.out_valid), 32'd1);
        chk("stall_hold", 32'({bus.out_data, bus.out_sop, bus.out_eop, bus.out_parity}), 32'(held));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $error("FAIL unexpected_out observed=%0h expected=none", bus.out_data);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", 32'(bus.out_data), 32'(e.d));
          chk("out_flags", 32'({bus.out_sop, bus.out_eop, bus.out_parity}), 32'({e.sop, e.eop, e.par}));
        end
        cw_q.push_back(bus.out_data);
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
      end
      hold_v = bus.out_valid && !bus.out_ready;
      held   = {bus.out_data, bus.out_sop, bus.out_eop, bus.out_parity};
      if (bus.in_valid && bus.in_ready) begin
        if (first_in < 0) first_in = cyc;
        e.d = msg[sent % len]; e.sop = (sent % len == 0); e.eop = 1'b0; e.par = 1'b0;
        exp_q.push_back(e);
        sent++;
        if (sent % len == 0) begin
          model_parity(len);
          for (int k = 0; k < NP; k++) begin
            e.d = par_m[k]; e.sop = 1'b0; e.eop = (k == NP - 1); e.par = 1'b1;
            exp_q.push_back(e);
          end
        end
      end
      @(posedge clk); #1;
      budget++;
    end
    if (budget >= 20000) begin
      checks++; errors++;
      $error("FAIL timeout observed=%0d expected<20000", budget);
      exp_q.delete();
    end
    bus.in_valid = 1'b0;
    lat_r  = first_out - first_in;
    span_r = last_out - first_in;
  endtask

  initial begin
    logic [7:0] s;
    int acc, budget, spurious;
    init_model();
    bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.out_ready = 1'b0;
`ifdef RS_ENC_SHORTEN_EN
    bus.in_last = 1'b0;
`endif
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out", 32'({bus.out_valid, bus.out_data, bus.out_sop, bus.out_eop, bus.out_parity}), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;

    // All-zero message, no stalls: 255 zero symbols back to back.
    for (int i = 0; i < K; i++) msg[i] = 8'h00;
    drive_words(K, 1, 1'b0, 1'b0);
    chk("zero_len", 32'(cw_q.size()), 32'(N));
    chk("zero_latency", 32'(lat_r), 32'd1);
    chk("zero_span", 32'(span_r), 32'(N));

    // Impulse: parity is the generator itself, g_15 down to g_0 = alpha^120.
    msg[K-1] = 8'h01;
    drive_words(K, 1, 1'b0, 1'b0);
    for (int k = 0; k < NP; k++) chk("impulse_g", 32'(cw_q[K+k]), 32'(g[NP-1-k]));
    chk("impulse_g0", 32'(cw_q[N-1]), 32'(exp_tab[120]));

    // Random message: every syndrome must vanish.
    for (int i = 0; i < K; i++) msg[i] = 8'($urandom);
    drive_words(K, 1, 1'b0, 1'b0);
    for (int i = 0; i < N; i++) ref_cw[i] = cw_q[i];
    for (int j = 0; j < NP; j++) begin
      s = 8'h00;
      for (int i = 0; i < N; i++) s = gmul(s, exp_tab[j]) ^ cw_q[i];
      chk("syndrome", 32'(s), 32'd0);
    end

    // Same message with random gaps and backpressure: identical codeword.
    drive_words(K, 1, 1'b1, 1'b0);
    chk("stall_len", 32'(cw_q.size()), 32'(N));
    for (int i = 0; i < N && i < cw_q.size(); i++) chk("stall_cw", 32'(cw_q[i]), 32'(ref_cw[i]));

    // Two codewords back to back: no idle cycle between them.
    drive_words(K, 2, 1'b0, 1'b0);
    chk("b2b_span", 32'(span_r), 32'(2*N));

    // Abort after 100 accepted symbols.
    acc = 0; budget = 0;
    bus.out_ready = 1'b1;
    while (acc < 100 && budget < 1000) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'($urandom);
      @(negedge clk);
      if (bus.in_ready) acc++;
      @(posedge clk); #1;
      budget++;
    end
    chk("abort_accepted", 32'(acc), 32'd100);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    rst = 1'b0;
    spurious = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.out_valid) spurious++;
    end
    chk("abort_no_parity", 32'(spurious), 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < K; i++) msg[i] = 8'h00;
    drive_words(K, 1, 1'b0, 1'b0);
    chk("abort_next_len", 32'(cw_q.size()), 32'(N));

`ifdef RS_ENC_SHORTEN_EN
    // Shortened word: in_last on symbol 10.
    for (int i = 0; i < 11; i++) msg[i] = 8'($urandom);
    drive_words(11, 1, 1'b0, 1'b1);
    chk("short_len", 32'(cw_q.size()), 32'd27);
    chk("short_span", 32'(span_r), 32'd27);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rs_encoder.md
# rs_encoder

Systematic Reed-Solomon encoder over GF(2^8), field polynomial p(x) = x^8+x^4+x^3+x^2+1 (0x11D), α = 0x02. Accepts a stream of message symbols over a valid/ready handshake, passes them through unchanged, then appends 2T parity symbols. It is the transmit-side counterpart of the RS decoder and produces codewords the decoder consumes directly. The constant multiplications use the codebase's GF(2^8) multiplier, one instance per generator coefficient.

## Interface
- m, 8, symbol width in bits; only 8 is supported.
- N, 255, codeword length in symbols.
- K, 239, message length in symbols; 2T = N-K = 16 parity symbols.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  in_data holds a message symbol.
- in_ready  out  1  encoder accepts in_data this cycle.
- in_data  in  m  message symbol, highest-degree coefficient first.
- in_last  in  1  last message symbol; present only with RS_ENC_SHORTEN_EN.
- out_valid  out  1  out_data holds a codeword symbol.
- out_ready  in  1  downstream accepts out_data this cycle.
- out_data  out  m  codeword symbol: K message symbols, then 2T parity symbols.
- out_sop  out  1  first symbol of a codeword.
- out_eop  out  1  last parity symbol of a codeword.
- out_parity  out  1  out_data is a parity symbol.

## Operation
- Generator polynomial g(x) = ∏(x + α^i) for i = 0..2T-1, monic. The 2T coefficients g_0..g_{2T-1} are compile-time constants derived from the parameters.
- Parity register r[0..2T-1] holds m bits per entry. On each accepted message symbol d:
  - fb = d ^ r[2T-1];
  - r[0] = fb·g_0;
  - r[i] = r[i-1] ^ fb·g_i for i ≥ 1.
- FSM states:
  - IDLE: r is all zero; in_ready asserted. First accepted symbol goes to DATA.
  - DATA: counts accepted symbols 0..K-1. The K-th symbol goes to PARITY.
  - PARITY: in_ready = 0. Each symbol transferred on the output shifts r up, with r[2T-1] emitted and 0 shifted into r[0]. After 2T transfers, return to IDLE and clear r.
- Message symbols are emitted unchanged with out_parity = 0. out_sop is high on the first message symbol. out_eop and out_parity are high on the last parity symbol.
- All GF addition is XOR. Counters are ceil(log2(N+1)) bits wide and never wrap within a codeword.

## Timing
- Reset values: in_ready = 0 while rst is high and 1 in the first cycle after; out_valid = 0; out_data = 0; out_sop = 0; out_eop = 0; out_parity = 0; r = 0; FSM = IDLE; counters = 0.
- A single output register stage holds the output. Message latency is 1 cycle: a symbol accepted in cycle t appears on out_data in cycle t+1.
- in_ready = (state ≠ PARITY) && (!out_valid || out_ready). No combinational path exists from in_valid to in_ready.
- The first parity symbol is valid in the cycle after the K-th message symbol is transferred. With out_ready held high, a codeword occupies N consecutive output cycles.
- Output stability: while out_valid = 1 and out_ready = 0, out_data and all flags hold and r does not shift.
- Back-to-back codewords: IDLE accepts a new symbol in the same cycle the last parity symbol transfers. Minimum gap is 0 idle input cycles beyond the 2T parity cycles.
- rst asserted mid-codeword: the partial codeword is discarded immediately, with no parity emitted.

## Configuration
- RS_ENC_SHORTEN_EN defined:
  - The in_last port exists. Accepting a symbol with in_last = 1 while in IDLE or DATA moves the FSM to PARITY after j+1 ≤ K symbols. This yields a shortened (j+1+2T, j+1) codeword, equivalent to zero-prefixing.
  - in_last on the K-th symbol behaves like the unshortened case.
  - in_last is ignored unless in_valid && in_ready.
- RS_ENC_SHORTEN_EN undefined: in_last is absent and every codeword is exactly K+2T symbols.

## Test plan
- K zero symbols, out_ready = 1 -> 255 output symbols, all 0x00. sop on output 0, eop and parity flag on output 254, parity flag on outputs 239..254.
- Message of 238 zeros then 0x01 -> the 16 parity symbols equal g_15, g_14, …, g_0 in that order. The last one is g_0 = α^120.
- Random message -> for each j = 0..15, evaluating the 255-symbol output at α^j gives 0, checked against a software RS model.
- Random out_ready toggling (50%) plus random in_valid gaps -> codeword identical to the no-stall run, and out_data never changes while stalled.
- rst pulse after 100 accepted symbols, then a full zero message -> no parity emitted for the aborted word, and the next codeword is all-zero.
- With RS_ENC_SHORTEN_EN: in_last on symbol 10 -> 27 output symbols, and the parity matches the model's 239-symbol encoding with 228 leading zeros.
